// File: rtl/retire_mon_pkg.sv
// Shared types and microword field layout for the retire monitor.
// Field positions refer to the 112-bit microword numbered [112:1].
package retire_mon_pkg;

    localparam int OP_W      = 112;
    localparam int SQI_CONT  = 14;
    localparam int MAP_PE    = 0;

    localparam int OP_SQI_HI = 112;
    localparam int OP_SQI_LO = 109;
    localparam int OP_A_HI   = 108;
    localparam int OP_A_LO   = 97;
    localparam int OP_MAP_HI = 96;
    localparam int OP_MAP_LO = 95;

    typedef enum logic [1:0] {
        CK_NONE = 2'd0,
        CK_PASS = 2'd1,
        CK_FAIL = 2'd2,
        CK_END  = 2'd3
    } ckpt_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } mon_state_t;

    // A PASS checkpoint is encoded as a CONT sequencer op with the PE map select.
    function automatic logic is_cont_pe(input logic [OP_W:1] op);
        return (op[OP_SQI_HI:OP_SQI_LO] == 4'(SQI_CONT)) &&
               (op[OP_MAP_HI:OP_MAP_LO] == 2'(MAP_PE));
    endfunction

endpackage

// File: rtl/retire_history_buf.sv
// Eight-entry ring of retired microaddresses with a wrapping write pointer.
// Read index 0 returns the newest entry; the read path is combinational.
module retire_history_buf #(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic [PC_W-1:0] wr_pc,
    input  logic [2:0]      rd_idx,
    output logic [PC_W-1:0] rd_pc
);

    localparam int DEPTH = 8;

    logic [2:0]      wr_ptr_reg;
    logic [PC_W-1:0] ring_reg [DEPTH];
    logic [2:0]      rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ring_reg[i] <= '0;
            end
        end else if (wr_en) begin
            ring_reg[wr_ptr_reg] <= wr_pc;
            wr_ptr_reg           <= wr_ptr_reg + 3'd1;
        end
    end

    // Newest entry sits just behind the write pointer; 3-bit arithmetic wraps.
    assign rd_ptr = wr_ptr_reg - 3'd1 - rd_idx;
    assign rd_pc  = ring_reg[rd_ptr];

endmodule

// File: rtl/uinstr_retire_monitor.sv
// Execute-stage retire monitor: pipelines fetch words, matches retires against a
// checkpoint table and tracks self-test status. RETIRE_MON_HISTORY_EN adds a retire-PC ring.
module uinstr_retire_monitor
    import retire_mon_pkg::*;
#(
    parameter int NUM_CKPT = 48,
    parameter int LIMIT    = 100000,
    parameter int PC_W     = 12
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            f_valid,
    input  logic [PC_W-1:0] f_pc,
    input  logic [112:1]    f_opcode,
    input  logic            x_stall,
    input  logic            flush,
    input  logic            cfg_we,
    input  logic [5:0]      cfg_idx,
    input  logic [1:0]      cfg_kind,
    input  logic [PC_W-1:0] cfg_label,
    input  logic            arm,
    input  logic            clear,
`ifdef RETIRE_MON_HISTORY_EN
    input  logic [2:0]      hist_idx,
    output logic [PC_W-1:0] hist_pc,
`endif
    output logic [PC_W-1:0] pc_x,
    output logic [112:1]    opcode_x,
    output logic            x_valid,
    output logic            retired,
    output logic            pass_hit,
    output logic [5:0]      pass_idx,
    output logic [7:0]      pass_count,
    output logic [31:0]     cycle_count,
    output logic [2:0]      status
);

    logic [PC_W-1:0] pc_x_reg;
    logic [OP_W:1]   opcode_x_reg;
    logic            x_valid_reg;

    mon_state_t      state_reg;
    mon_state_t      state_next;

    ckpt_kind_t      kind_reg  [NUM_CKPT];
    logic [PC_W-1:0] label_reg [NUM_CKPT];

    logic            pass_hit_reg;
    logic            pass_hit_next;
    logic [5:0]      pass_idx_reg;
    logic [5:0]      pass_idx_next;
    logic [7:0]      pass_count_reg;
    logic [7:0]      pass_count_next;
    logic [31:0]     cycle_count_reg;
    logic [31:0]     cycle_count_next;

    logic [NUM_CKPT-1:0] pass_vec;
    logic [NUM_CKPT-1:0] fail_vec;
    logic [NUM_CKPT-1:0] end_vec;
    logic [5:0]          pass_sel;
    logic                op_cont_pe;
    logic [PC_W-1:0]     op_a;
    logic                in_run;
    logic                cfg_ok;
    logic                pass_now;
    logic                fail_now;
    logic                end_now;
    logic                timeout_now;

    // Execute stage: a stall freezes the word but a flush still kills it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_x_reg     <= '0;
            opcode_x_reg <= '0;
            x_valid_reg  <= 1'b0;
        end else if (!x_stall) begin
            pc_x_reg     <= f_pc;
            opcode_x_reg <= f_opcode;
            x_valid_reg  <= f_valid & ~flush;
        end else if (flush) begin
            x_valid_reg  <= 1'b0;
        end
    end

    assign retired = x_valid_reg & ~x_stall;
    assign in_run  = (state_reg == ST_RUN);
    assign cfg_ok  = cfg_we && (state_reg == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                kind_reg[i]  <= CK_NONE;
                label_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (cfg_ok && (cfg_idx == 6'(i))) begin
                    kind_reg[i]  <= ckpt_kind_t'(cfg_kind);
                    label_reg[i] <= cfg_label;
                end
            end
        end
    end

    assign op_cont_pe = is_cont_pe(opcode_x_reg);
    assign op_a       = PC_W'(opcode_x_reg[OP_A_HI:OP_A_LO]);

    generate
        for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_match
            assign pass_vec[gi] = (kind_reg[gi] == CK_PASS) && op_cont_pe &&
                                  (op_a == label_reg[gi]);
            assign fail_vec[gi] = (kind_reg[gi] == CK_FAIL) && (pc_x_reg == label_reg[gi]);
            assign end_vec[gi]  = (kind_reg[gi] == CK_END)  && (pc_x_reg == label_reg[gi]);
        end
    endgenerate

    // Lowest matching PASS index wins.
    always_comb begin
        pass_sel = '0;
        for (int i = NUM_CKPT - 1; i >= 0; i--) begin
            if (pass_vec[i]) begin
                pass_sel = 6'(i);
            end
        end
    end

    assign pass_now    = retired && (|pass_vec);
    assign fail_now    = retired && (|fail_vec);
    assign end_now     = retired && (|end_vec);
    assign timeout_now = (cycle_count_reg == 32'(LIMIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arm) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (fail_now)         state_next = ST_FAIL;
                    else if (end_now)     state_next = ST_PASS;
                    else if (timeout_now) state_next = ST_TIMEOUT;
                end
                default: state_next = state_reg;
            endcase
        end
    end

    // A FAIL or TIMEOUT in the same cycle swallows the PASS hit; an END keeps it.
    always_comb begin
        pass_hit_next    = 1'b0;
        pass_idx_next    = pass_idx_reg;
        pass_count_next  = pass_count_reg;
        cycle_count_next = cycle_count_reg;
        status           = state_reg;
        if (clear) begin
            pass_idx_next    = '0;
            pass_count_next  = '0;
            cycle_count_next = '0;
        end else if ((state_reg == ST_IDLE) && arm) begin
            pass_count_next  = '0;
            cycle_count_next = '0;
        end else if (in_run) begin
            if (cycle_count_reg != '1) begin
                cycle_count_next = cycle_count_reg + 32'd1;
            end
            if (pass_now && !fail_now && (end_now || !timeout_now)) begin
                pass_hit_next = 1'b1;
                pass_idx_next = pass_sel;
                if (pass_count_reg != 8'hFF) begin
                    pass_count_next = pass_count_reg + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass_hit_reg    <= 1'b0;
            pass_idx_reg    <= '0;
            pass_count_reg  <= '0;
            cycle_count_reg <= '0;
        end else begin
            pass_hit_reg    <= pass_hit_next;
            pass_idx_reg    <= pass_idx_next;
            pass_count_reg  <= pass_count_next;
            cycle_count_reg <= cycle_count_next;
        end
    end

`ifdef RETIRE_MON_HISTORY_EN
    retire_history_buf #(
        .PC_W(PC_W)
    ) u_hist (
        .clk    (clk),
        .reset_n(reset_n),
        .wr_en  (retired && in_run),
        .wr_pc  (pc_x_reg),
        .rd_idx (hist_idx),
        .rd_pc  (hist_pc)
    );
`endif

    assign pc_x        = pc_x_reg;
    assign opcode_x    = opcode_x_reg;
    assign x_valid     = x_valid_reg;
    assign pass_hit    = pass_hit_reg;
    assign pass_idx    = pass_idx_reg;
    assign pass_count  = pass_count_reg;
    assign cycle_count = cycle_count_reg;

endmodule
